writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Final pipeline stage. Accepts completed instructions from MEM, waits for load data, and extracts and extends sub-word loads.
- Retires through the register-file write port that decode consumes (OUT_DE_DR/OUT_DE_Data/OUT_DE_REG_WEN).
- Drives WB_DR/WB_V back to decode for hazard stalls, stalls MEM while a load is outstanding, and counts retired instructions.

Parameters:
INSTRET_W, 64, width of retired-instruction counter
LOAD_TIMEOUT, 255, max cycles waiting in WAIT_LOAD before abort; 0 disables timeout

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset (0 = reset)
MEM_V  in  1  MEM presents valid instruction
MEM_IR  in  32  instruction
MEM_RESULT  in  64  ALU/link result (NPC for JAL/JALR, address for loads)
MEM_RDATA  in  64  aligned doubleword from data memory
MEM_RVALID  in  1  MEM_RDATA valid this cycle
WB_STALL  out  1  WB cannot accept; MEM must hold
WB_V  out  1  WB holds instruction that will write nonzero rd
WB_DR  out  5  rd of held instruction (0 when WB_V=0)
OUT_DE_REG_WEN  out  1  register-file write enable
OUT_DE_DR  out  5  write register
OUT_DE_Data  out  64  write data
INSTRET  out  INSTRET_W  retired-instruction count
LOAD_ERR  out  1  sticky, load timeout occurred

Behaviour:
- Reset (async, RESET=0): state EMPTY. All outputs 0; INSTRET=0, LOAD_ERR=0. Held instruction and pending load are discarded. Registers capture on the first posedge after RESET=1.
- writes_rd: opcode[6:2] in {00000 LOAD, 00100, 00110, 01100, 01110, 01101 LUI, 00101 AUIPC, 11011 JAL, 11001 JALR}. Other opcodes (STORE, BRANCH, etc.) retire without a write.
- States:
  - EMPTY: nothing held.
  - WAIT_LOAD: load held, data not yet returned.
  - COMMIT: result ready; write occurs this cycle.
- Accept: on posedge, if MEM_V=1 and WB_STALL=0, latch IR, RESULT, addr_lo=MEM_RESULT[2:0]. Next state is WAIT_LOAD for LOAD, otherwise COMMIT. No accept leads to EMPTY, from EMPTY or COMMIT.
- WB_STALL=1 only in WAIT_LOAD. In COMMIT, WB_STALL=0, so back-to-back accept gives 1 instr/cycle for non-loads.
- WAIT_LOAD: MEM_RVALID is sampled only in this state and ignored elsewhere.
  - MEM_RVALID=1: latch extracted data, go to COMMIT. Earliest load commit is 2 cycles after accept.
  - Wait counter resets on entry. If LOAD_TIMEOUT!=0 and the counter reaches LOAD_TIMEOUT without MEM_RVALID: set LOAD_ERR (sticky), go to COMMIT with the write suppressed.
- COMMIT, combinational:
  - OUT_DE_REG_WEN=1 iff writes_rd, rd!=0 and the load was not aborted.
  - OUT_DE_DR=rd; OUT_DE_Data=final value.
  - OUT_DE_REG_WEN=0, OUT_DE_DR=0, OUT_DE_Data=0 outside COMMIT.
- INSTRET increments by 1 on each posedge leaving COMMIT, including aborted loads and non-writing instructions. Wraps at 2^INSTRET_W.
- WB_V=1 when state!=EMPTY, writes_rd and rd!=0; WB_DR=rd when WB_V=1, else 0. WB_V stays high through COMMIT, so decode sees the hazard until the write edge.
- Result formation:
  - OP-IMM-32 / OP-32: {{32{RESULT[31]}}, RESULT[31:0]}.
  - Other non-loads: RESULT unchanged.
  - Loads: shifted = MEM_RDATA >> (8*addr_lo); bytes beyond bit 63 read as 0. Then by funct3:
    - 000 LB: sext shifted[7:0]
    - 001 LH: sext [15:0]
    - 010 LW: sext [31:0]
    - 011 LD: [63:0]
    - 100 LBU: zext [7:0]
    - 101 LHU: zext [15:0]
    - 110 LWU: zext [31:0]
    - 111: treated as LD
- rd=0: instruction retires, no write, WB_V=0.
- Reset asserted in WAIT_LOAD or COMMIT: the instruction is dropped with no write and no INSTRET increment.

Test Plan:
- Reset: RESET=0 mid-COMMIT (RESULT=5, rd=x3) -> OUT_DE_REG_WEN, WB_V, INSTRET, LOAD_ERR go 0 immediately, with no clock edge.
- ALU stream: addi x1 then add x2 on consecutive cycles, RESULT 0x10 and 0x20 -> WEN high two consecutive cycles, DR=1/Data=0x10 then DR=2/Data=0x20; WB_STALL=0 throughout; INSTRET=2.
- Load extension:
  - LB, addr_lo=3, RDATA=0x00000000_80FF0000 -> DR written 0xFFFF_FFFF_FFFF_FF80.
  - Same access with LBU -> 0x80.
  - LWU, addr_lo=4, RDATA=0x8765_4321_0000_0000 -> 0x0000_0000_8765_4321.
- Load latency: MEM_RVALID arrives 3 cycles after accept -> WB_STALL=1 for exactly those 3 cycles; WB_V=1, WB_DR=rd throughout; single write the following cycle.
- Timeout: LOAD_TIMEOUT=4, no MEM_RVALID -> LOAD_ERR=1 after 4 wait cycles; no write; INSTRET+1; LOAD_ERR stays 1 across further instructions.
- Non-writers: sw, beq, addi x0,x0,7 -> WB_V=0, WEN never 1, INSTRET+3; addiw with RESULT=0x0000_0000_8000_0000 -> Data 0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: waits for load data, formats results,
// retires through the register-file write port and counts retirements.
module writeback_stage #(
  parameter int INSTRET_W    = 64,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 MEM_V,
  input  logic [31:0]          MEM_IR,
  input  logic [63:0]          MEM_RESULT,
  input  logic [63:0]          MEM_RDATA,
  input  logic                 MEM_RVALID,
  output logic                 WB_STALL,
  output logic                 WB_V,
  output logic [4:0]           WB_DR,
  output logic                 OUT_DE_REG_WEN,
  output logic [4:0]           OUT_DE_DR,
  output logic [63:0]          OUT_DE_Data,
  output logic [INSTRET_W-1:0] INSTRET,
  output logic                 LOAD_ERR
);

  typedef enum logic [1:0] {
    EMPTY,
    WAIT_LOAD,
    COMMIT
  } state_e;

  localparam logic [31:0] TO = 32'(LOAD_TIMEOUT);

  state_e               state_q, state_d;
  logic [4:0]           op_q, op_d;
  logic [4:0]           rd_q, rd_d;
  logic [2:0]           f3_q, f3_d;
  logic [2:0]           lo_q, lo_d;
  logic [63:0]          res_q, res_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic [63:0] shifted;
  logic [63:0] ld_val;
  logic [63:0] alu_val;
  logic        wr;
  logic        commit;

  wire unused_ir = ^{MEM_IR[31:15], MEM_IR[1:0]};

  function automatic logic writes_rd(input logic [4:0] op);
    return op inside {5'b00000, 5'b00100, 5'b00110,
                      5'b01100, 5'b01110, 5'b01101,
                      5'b00101, 5'b11011, 5'b11001};
  endfunction

  // shifting out the low bytes zero-fills past bit 63
  assign shifted = MEM_RDATA >> {lo_q, 3'b000};

  always_comb begin
    ld_val = shifted;
    unique case (f3_q)
      3'b000:  ld_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ld_val = {56'd0, shifted[7:0]};
      3'b101:  ld_val = {48'd0, shifted[15:0]};
      3'b110:  ld_val = {32'd0, shifted[31:0]};
      default: ld_val = shifted;
    endcase
  end

  always_comb begin
    alu_val = MEM_RESULT;
    unique case (1'b1)
      MEM_IR[6:2] == 5'b00110,
      MEM_IR[6:2] == 5'b01110:
        alu_val = {{32{MEM_RESULT[31]}}, MEM_RESULT[31:0]};
      default: alu_val = MEM_RESULT;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    lo_d      = lo_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    err_d     = err_q;
    instret_d = instret_q;
    if (state_q == COMMIT) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
    case (state_q)
      WAIT_LOAD: begin
        if (MEM_RVALID) begin
          res_d   = ld_val;
          state_d = COMMIT;
        end else if (TO != 32'd0 && cnt_q == TO - 32'd1) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        if (MEM_V) begin
          op_d    = MEM_IR[6:2];
          rd_d    = MEM_IR[11:7];
          f3_d    = MEM_IR[14:12];
          lo_d    = MEM_RESULT[2:0];
          res_d   = alu_val;
          cnt_d   = 32'd0;
          abort_d = 1'b0;
          state_d = (MEM_IR[6:2] == 5'b00000) ? WAIT_LOAD : COMMIT;
        end else begin
          state_d = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= EMPTY;
      op_q      <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

  assign commit = (state_q == COMMIT);
  assign wr     = writes_rd(op_q) && (rd_q != 5'd0);

  assign WB_STALL       = (state_q == WAIT_LOAD);
  assign WB_V           = (state_q != EMPTY) && wr;
  assign WB_DR          = WB_V ? rd_q : 5'd0;
  assign OUT_DE_REG_WEN = commit && wr && !abort_q;
  assign OUT_DE_DR      = commit ? rd_q : 5'd0;
  assign OUT_DE_Data    = commit ? res_q : 64'd0;
  assign INSTRET        = instret_q;
  assign LOAD_ERR       = err_q;

endmodule
